// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS front-end blocks.
//   word_t            32-bit machine word
//   fetch_state_t     fetch-unit sequencer states
//   RESET_VECTOR_DEF  default PC after reset
//   PC_INC_DEF        sequential PC step in bytes
package mips_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
  } fetch_state_t;

  localparam word_t       RESET_VECTOR_DEF = 32'h0040_0000;
  localparam int unsigned PC_INC_DEF       = 4;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: picks the PC to load after a retire and flags a
// target that is not word aligned.
//   pc_plus4   in   sequential successor of the current PC
//   jump_sel   in   retiring instruction redirects the PC
//   jump_pc    in   redirect target from the ALU
//   next_pc    out  selected next PC
//   misaligned out  next_pc[1:0] is non-zero
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic        jump_sel,
  input  logic [31:0] jump_pc,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc    = jump_sel ? jump_pc : pc_plus4;
    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus instruction fetch sequencer.
// Fetches the word at pc_o over a req/ack handshake, presents it to
// decode until the execute stage retires it, then loads PC+4 or the
// ALU target. A misaligned next PC parks the unit in a sticky trap
// that only reset clears.
//   clk, reset                  clock, synchronous active-high reset
//   jump_sel_i, jump_pc_i       redirect select/target (retire cycle only)
//   retire_i, stall_i           execute-stage retire, hold (stall wins)
//   imem_req_o, imem_addr_o     fetch request and address
//   imem_ack_i, imem_rdata_i    fetch completion and data
//   pc_o, pc_plus4_o            current PC and its successor
//   instr_o, instr_valid_o      latched instruction, awaiting retire
//   instr_count_o               retired-instruction count (wraps)
//   misalign_o, bad_addr_o      sticky trap flag and offending target
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter word_t       RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned PC_INC       = PC_INC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_sel_i,
  input  logic [31:0] jump_pc_i,
  input  logic        retire_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_count_o,
  output logic        misalign_o,
  output logic [31:0] bad_addr_o
);

  fetch_state_t state_q, state_d;

  word_t pc_q;
  word_t instr_q;
  word_t count_q;
  word_t bad_addr_q;
  logic  misalign_q;

  word_t pc_plus4;
  word_t next_pc;
  logic  next_misaligned;
  logic  fetch_done;
  logic  retire_go;

  // Wraps modulo 2^32 by construction of the 32-bit add.
  assign pc_plus4   = pc_q + word_t'(PC_INC);
  assign fetch_done = (state_q == ST_FETCH) && imem_ack_i;
  assign retire_go  = (state_q == ST_EXEC) && retire_i && !stall_i;

  pc_next_sel u_pc_next_sel (
    .pc_plus4  (pc_plus4),
    .jump_sel  (jump_sel_i),
    .jump_pc   (jump_pc_i),
    .next_pc   (next_pc),
    .misaligned(next_misaligned)
  );

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples
  // pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_ack_i) state_d = ST_EXEC;
      ST_EXEC:  if (retire_go) state_d = next_misaligned ? ST_TRAP : ST_FETCH;
      ST_TRAP:  state_d = ST_TRAP;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath registers. Reset is synchronous and checked first, so an
  // ack or retire in the reset cycle latches nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      instr_q    <= '0;
      count_q    <= '0;
      bad_addr_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (fetch_done) instr_q <= imem_rdata_i;
      if (retire_go) begin
        if (next_misaligned) begin
          // PC and count stay on the faulting instruction.
          bad_addr_q <= next_pc;
          misalign_q <= 1'b1;
        end else begin
          pc_q    <= next_pc;
          count_q <= count_q + 32'd1;
        end
      end
    end
  end

  // Output logic.
  always_comb begin
    imem_req_o    = (state_q == ST_FETCH);
    instr_valid_o = (state_q == ST_EXEC);
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign instr_o       = instr_q;
  assign instr_count_o = count_q;
  assign misalign_o    = misalign_q;
  assign bad_addr_o    = bad_addr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit. Directed stimulus pushes expected fetch
// addresses and expected presented instructions into queues; a monitor
// pops and compares on each new request and each new valid instruction.
module tb_pc_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] count;
  } exec_exp_t;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        jump_sel_i;
  logic [31:0] jump_pc_i;
  logic        retire_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] instr_count_o;
  logic        misalign_o;
  logic [31:0] bad_addr_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] fetch_q[$];
  exec_exp_t   exec_q[$];

  pc_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .jump_sel_i   (jump_sel_i),
    .jump_pc_i    (jump_pc_i),
    .retire_i     (retire_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .instr_o      (instr_o),
    .instr_valid_o(instr_valid_o),
    .instr_count_o(instr_count_o),
    .misalign_o   (misalign_o),
    .bad_addr_o   (bad_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares on the first cycle of each request and each
  // presented instruction.
  logic prev_req   = 1'b0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (imem_req_o === 1'b1 && !prev_req) begin
      if (fetch_q.size() == 0) begin
        check("unexpected_fetch", imem_addr_o, 32'hxxxx_xxxx);
      end else begin
        check("fetch_addr", imem_addr_o, fetch_q.pop_front());
      end
    end
    if (instr_valid_o === 1'b1 && !prev_valid) begin
      if (exec_q.size() == 0) begin
        check("unexpected_valid", instr_o, 32'hxxxx_xxxx);
      end else begin
        exec_exp_t e;
        e = exec_q.pop_front();
        check("exec_instr", instr_o, e.instr);
        check("exec_pc", pc_o, e.pc);
        check("exec_pc_plus4", pc_plus4_o, e.pc_plus4);
        check("exec_count", instr_count_o, e.count);
      end
    end
    prev_req   = (imem_req_o === 1'b1);
    prev_valid = (instr_valid_o === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exec(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] count);
    exec_exp_t e;
    e.instr    = instr;
    e.pc       = pc;
    e.pc_plus4 = pc + 32'd4;
    e.count    = count;
    exec_q.push_back(e);
  endtask

  // Waits (bounded) for a request, acks after 'delay' cycles, then
  // confirms the instruction is valid on the following cycle.
  task automatic fetch(input logic [31:0] rdata, input int delay);
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'd0, imem_req_o}, 32'd1);
    for (int i = 0; i < delay; i++) tick();
    imem_ack_i   = 1'b1;
    imem_rdata_i = rdata;
    tick();
    imem_ack_i   = 1'b0;
    imem_rdata_i = 32'h0;
    check("valid_after_ack", {31'd0, instr_valid_o}, 32'd1);
  endtask

  task automatic retire(input logic jsel, input logic [31:0] jpc);
    retire_i   = 1'b1;
    jump_sel_i = jsel;
    jump_pc_i  = jpc;
    tick();
    retire_i   = 1'b0;
    jump_sel_i = 1'b0;
    jump_pc_i  = 32'h0;
  endtask

  initial begin
    reset        = 1'b1;
    jump_sel_i   = 1'b0;
    jump_pc_i    = 32'h0;
    retire_i     = 1'b0;
    stall_i      = 1'b0;
    imem_ack_i   = 1'b0;
    imem_rdata_i = 32'h0;

    // Reset state.
    tick();
    tick();
    check("rst_pc", pc_o, RV);
    check("rst_pc_plus4", pc_plus4_o, RV + 32'd4);
    check("rst_instr", instr_o, 32'h0);
    check("rst_count", instr_count_o, 32'h0);
    check("rst_bad_addr", bad_addr_o, 32'h0);
    check("rst_strobes", {29'd0, imem_req_o, instr_valid_o, misalign_o}, 32'd0);

    // First fetch, ack three cycles after req.
    fetch_q.push_back(RV);
    push_exec(32'h2008_000A, RV, 32'd0);
    reset = 1'b0;
    fetch(32'h2008_000A, 3);

    // Sequential retire.
    fetch_q.push_back(RV + 32'd4);
    push_exec(32'h1111_0001, RV + 32'd4, 32'd1);
    retire(1'b0, 32'hDEAD_0000);
    check("valid_drops_after_retire", {31'd0, instr_valid_o}, 32'd0);
    fetch(32'h1111_0001, 1);

    // Taken jump; zero-latency ack.
    fetch_q.push_back(32'h0040_0020);
    push_exec(32'h2222_0002, 32'h0040_0020, 32'd2);
    retire(1'b1, 32'h0040_0020);
    fetch(32'h2222_0002, 0);

    // Stall blocks retire.
    stall_i  = 1'b1;
    retire_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc_o, 32'h0040_0020);
      check("stall_count", instr_count_o, 32'd2);
      check("stall_valid", {31'd0, instr_valid_o}, 32'd1);
    end
    stall_i = 1'b0;
    fetch_q.push_back(32'h0040_0024);
    push_exec(32'h3333_0003, 32'h0040_0024, 32'd3);
    retire(1'b0, 32'h0);
    check("unstall_pc", pc_o, 32'h0040_0024);
    fetch(32'h3333_0003, 2);

    // Misaligned target traps; ack during trap is ignored.
    retire(1'b1, 32'h0040_0022);
    imem_ack_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("trap_misalign", {31'd0, misalign_o}, 32'd1);
      check("trap_strobes", {30'd0, imem_req_o, instr_valid_o}, 32'd0);
      if (i == 0) begin
        check("trap_bad_addr", bad_addr_o, 32'h0040_0022);
        check("trap_pc", pc_o, 32'h0040_0024);
        check("trap_count", instr_count_o, 32'd3);
      end
      tick();
    end
    imem_ack_i = 1'b0;
    check("trap_instr_kept", instr_o, 32'h3333_0003);

    // Reset clears the trap and fetching resumes at the vector.
    reset = 1'b1;
    tick();
    check("rst2_misalign", {31'd0, misalign_o}, 32'd0);
    check("rst2_bad_addr", bad_addr_o, 32'h0);
    check("rst2_pc", pc_o, RV);
    fetch_q.push_back(RV);
    push_exec(32'hAAAA_000A, RV, 32'd0);
    reset = 1'b0;
    fetch(32'hAAAA_000A, 1);

    // Reset mid-fetch with a simultaneous ack, then a late ack.
    fetch_q.push_back(RV + 32'd4);
    retire(1'b0, 32'h0);
    reset        = 1'b1;
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    check("rst_ack_instr", instr_o, 32'h0);
    check("rst_ack_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_ack_pc", pc_o, RV);
    check("rst_ack_count", instr_count_o, 32'd0);
    fetch_q.push_back(RV);
    push_exec(32'hBBBB_000B, RV, 32'd0);
    reset = 1'b0;
    tick();
    imem_ack_i   = 1'b0;
    imem_rdata_i = 32'h0;
    check("late_ack_ignored", {31'd0, instr_valid_o}, 32'd0);
    fetch(32'hBBBB_000B, 0);

    // Wrap: jump to the top word, then step past it.
    fetch_q.push_back(32'hFFFF_FFFC);
    push_exec(32'hCCCC_000C, 32'hFFFF_FFFC, 32'd1);
    retire(1'b1, 32'hFFFF_FFFC);
    fetch(32'hCCCC_000C, 0);
    fetch_q.push_back(32'h0000_0000);
    push_exec(32'hDDDD_000D, 32'h0000_0000, 32'd2);
    retire(1'b0, 32'h0);
    check("wrap_no_trap", {31'd0, misalign_o}, 32'd0);
    check("wrap_pc", pc_o, 32'h0);

    // Retire while fetching is ignored.
    retire(1'b1, 32'h0000_0100);
    check("retire_in_fetch_pc", pc_o, 32'h0);
    check("retire_in_fetch_count", instr_count_o, 32'd2);
    fetch(32'hDDDD_000D, 0);

    tick();
    tick();
    check("fetch_q_empty", fetch_q.size(), 32'd0);
    check("exec_q_empty", exec_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit in case a wait goes wrong.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential front end of the MIPS core: holds the program counter and fetches each instruction from instruction memory over a req/ack handshake.
- Presents the instruction to decode, waits for the execute stage to retire it, then loads the next PC (PC+4, or the ALU branch/jump target).
- Upstream of the ALU: drives its pc input with pc_plus4_o. Also downstream of the ALU: consumes its jump_pc result.

Parameters:
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset.
- PC_INC, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- jump_sel_i  input  1  retiring instruction is a branch/jump; take jump_pc_i as next PC.
- jump_pc_i  input  32  ALU branch/jump target (already equals PC+4 for a not-taken branch).
- retire_i  input  1  execute stage has finished the instruction on instr_o.
- stall_i  input  1  hold; blocks retire_i.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  32  fetch address.
- imem_ack_i  input  1  fetch data valid this cycle.
- imem_rdata_i  input  32  fetched instruction word.
- pc_o  output  32  PC of the current instruction.
- pc_plus4_o  output  32  pc_o + PC_INC, mod 2^32; feeds the ALU pc input.
- instr_o  output  32  latched instruction.
- instr_valid_o  output  1  instr_o valid, awaiting retire.
- instr_count_o  output  32  retired-instruction counter.
- misalign_o  output  1  sticky misaligned-target trap.
- bad_addr_o  output  32  offending target captured at trap.

Behaviour:
Reset:
- Sampled on clk only.
- pc_o=RESET_VECTOR, pc_plus4_o=RESET_VECTOR+4, instr_o=0, instr_count_o=0, bad_addr_o=0.
- imem_req_o=0, instr_valid_o=0, misalign_o=0.
- State goes to IDLE. Reset overrides every other input in the same cycle.

State machine (IDLE, FETCH, EXEC, TRAP):
- IDLE: all strobes 0; goes to FETCH on the next cycle unconditionally.
- FETCH:
  - imem_req_o=1; imem_addr_o=pc_o, held stable until ack.
  - On imem_ack_i, latch imem_rdata_i into instr_o and go to EXEC.
  - Minimum latency: ack in the first FETCH cycle gives instr_valid_o=1 on the next cycle.
  - Req is held indefinitely; there is no timeout.
- EXEC:
  - instr_valid_o=1, imem_req_o=0.
  - If stall_i=1: hold everything; retire_i is ignored.
  - Else if retire_i=1: next = jump_sel_i ? jump_pc_i : pc_plus4_o.
    - If next[1:0]!=0: go to TRAP, bad_addr_o<=next, misalign_o<=1; pc_o and instr_count_o unchanged.
    - Otherwise: pc_o<=next, instr_count_o<=instr_count_o+1, go to FETCH.
  - instr_valid_o deasserts in the cycle after retire.
- TRAP:
  - imem_req_o=0, instr_valid_o=0, misalign_o=1.
  - Only reset exits this state.

imem_addr_o:
- Equals pc_o in every state; it is only meaningful while imem_req_o=1.

Boundaries:
- imem_ack_i outside FETCH is ignored. This includes a late ack after reset mid-fetch.
- retire_i outside EXEC is ignored.
- jump_pc_i and jump_sel_i are sampled only in the retire cycle.
- PC arithmetic wraps modulo 2^32: 0xFFFF_FFFC+4=0x0000_0000, with no trap.
- instr_count_o wraps from 0xFFFF_FFFF to 0.
- Reset asserted in the same cycle as ack or retire: reset wins and nothing is latched.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding typedef (IDLE, FETCH, EXEC, TRAP);
  - RESET_VECTOR default and PC_INC constants;
  - a 32-bit word typedef.
- One sub-module, pc_next_sel: combinational next-PC mux plus alignment check.
  - Inputs: pc_plus4, jump_sel, jump_pc.
  - Outputs: next_pc, misaligned.

Test Plan:
- Reset 2 cycles, ack 3 cycles after req with rdata 32'h2008_000A -> imem_addr_o=32'h0040_0000; instr_valid_o=1 on the cycle after ack; instr_o=32'h2008_000A; pc_plus4_o=32'h0040_0004.
- Retire with jump_sel_i=0 -> next req at 32'h0040_0004; instr_count_o=1.
- Retire with jump_sel_i=1, jump_pc_i=32'h0040_0020 -> next imem_addr_o=32'h0040_0020; count increments.
- stall_i=1 and retire_i=1 for 3 cycles -> pc_o and instr_count_o unchanged, instr_valid_o stays 1. Drop stall with retire=1 -> advance next cycle.
- Retire with jump_pc_i=32'h0040_0022 -> misalign_o=1, bad_addr_o=32'h0040_0022, imem_req_o=0 for 10 cycles, pc_o unchanged. Reset -> normal fetch from RESET_VECTOR.
- Reset asserted during FETCH with imem_ack_i=1 in the same cycle -> instr_o=0, instr_valid_o=0, pc_o=RESET_VECTOR. Jump to 32'hFFFF_FFFC then a sequential retire -> pc_o=0, no trap.
